// File: rtl/calc1_port_sched.sv
// calc1_port_sched
//
// Lets four requesters share one single-port calc1 engine. Each requester
// sends a two-cycle command: cmd + operand1, then operand2. The command is
// held in that port's slot until the round-robin arbiter grants it. It is then
// replayed to the engine with the same two-cycle protocol. The engine's
// response is routed back to the port that issued the command. If the engine
// never answers, a timeout guard produces a synthetic error response.
//
// Ports
//   c_clk, reset_n              clock (rising edge); async active-low reset
//   reqN_cmd_in  [CMD_W]        requester N command, 0 = no request
//   reqN_data_in [DATA_W]       operand1 in the cmd cycle, operand2 the cycle after
//   out_respN    [2]            0 none, 1 success, 2 error (engine error or timeout)
//   out_dataN    [DATA_W]       result while out_respN != 0, else 0
//   eng_cmd_out  [CMD_W]        command to the engine (ISSUE1 only)
//   eng_data_out [DATA_W]       operand1 in ISSUE1, operand2 in ISSUE2, else 0
//   eng_resp_in  [2]            engine response, nonzero for one cycle
//   eng_data_in  [DATA_W]       engine result
//   busy                        engine FSM not in IDLE
//   err_protocol                sticky protocol-violation flag
module calc1_port_sched #(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [CMD_W-1:0]  req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [CMD_W-1:0]  req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [CMD_W-1:0]  req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [CMD_W-1:0]  req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4,
  output logic [CMD_W-1:0]  eng_cmd_out,
  output logic [DATA_W-1:0] eng_data_out,
  input  logic [1:0]        eng_resp_in,
  input  logic [DATA_W-1:0] eng_data_in,
  output logic              busy,
  output logic              err_protocol
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The timeout fires after TIMEOUT-1 silent WAIT_RESP cycles. The error
  // response is then visible exactly TIMEOUT cycles after ISSUE2. This is the
  // same cycle in which a real response sampled in that last wait cycle
  // would appear.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_OP1,
    SLOT_PENDING,
    SLOT_SERVICE
  } slotState_e;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_ISSUE1,
    ENG_ISSUE2,
    ENG_WAIT_RESP
  } engState_e;

  logic [CMD_W-1:0]  reqCmd  [4];
  logic [DATA_W-1:0] reqData [4];

  slotState_e        slotState_q [4];
  slotState_e        slotState_d [4];
  logic [CMD_W-1:0]  slotCmd_q   [4];
  logic [CMD_W-1:0]  slotCmd_d   [4];
  logic [DATA_W-1:0] slotOp1_q   [4];
  logic [DATA_W-1:0] slotOp1_d   [4];
  logic [DATA_W-1:0] slotOp2_q   [4];
  logic [DATA_W-1:0] slotOp2_d   [4];

  engState_e         engState_q, engState_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        resp_q  [4];
  logic [1:0]        resp_d  [4];
  logic [DATA_W-1:0] rdata_q [4];
  logic [DATA_W-1:0] rdata_d [4];

  logic              errProt_q, errProt_d;

  logic              anyPending;
  logic [1:0]        pickIdx;
  logic              grantFire;
  logic              respFire;
  logic              timeoutFire;
  logic              done;
  logic              slotErr;

  assign reqCmd[0]  = req1_cmd_in;
  assign reqCmd[1]  = req2_cmd_in;
  assign reqCmd[2]  = req3_cmd_in;
  assign reqCmd[3]  = req4_cmd_in;
  assign reqData[0] = req1_data_in;
  assign reqData[1] = req2_data_in;
  assign reqData[2] = req3_data_in;
  assign reqData[3] = req4_data_in;

  // Round-robin pick: the first PENDING slot at or after the pointer. The
  // 2-bit index wraps naturally from port 4 back to port 1.
  always_comb begin
    anyPending = 1'b0;
    pickIdx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!anyPending && slotState_q[ptr_q + 2'(k)] == SLOT_PENDING) begin
        anyPending = 1'b1;
        pickIdx    = ptr_q + 2'(k);
      end
    end
  end

  assign grantFire   = (engState_q == ENG_IDLE) && anyPending;
  assign respFire    = (engState_q == ENG_WAIT_RESP) && (eng_resp_in != 2'b00);
  // A real response in the final wait cycle wins over the timeout.
  assign timeoutFire = (engState_q == ENG_WAIT_RESP) && (eng_resp_in == 2'b00) &&
                       (cnt_q == CNT_LAST);
  assign done        = respFire || timeoutFire;

  // Engine-side FSM. The engine outputs are decoded from the state, so they
  // are zero whenever the FSM is IDLE or waiting.
  always_comb begin
    engState_d   = engState_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    eng_cmd_out  = '0;
    eng_data_out = '0;
    case (engState_q)
      ENG_IDLE: begin
        if (anyPending) begin
          grant_d    = pickIdx;
          ptr_d      = pickIdx + 2'd1;
          engState_d = ENG_ISSUE1;
        end
      end
      ENG_ISSUE1: begin
        eng_cmd_out  = slotCmd_q[grant_q];
        eng_data_out = slotOp1_q[grant_q];
        engState_d   = ENG_ISSUE2;
      end
      ENG_ISSUE2: begin
        eng_data_out = slotOp2_q[grant_q];
        cnt_d        = '0;
        engState_d   = ENG_WAIT_RESP;
      end
      ENG_WAIT_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done) begin
          engState_d = ENG_IDLE;
        end
      end
      default: engState_d = ENG_IDLE;
    endcase
  end

  // Per-port capture slots. A nonzero command while a slot is PENDING or
  // in service is dropped and flagged. The command input is ignored during
  // the operand2 cycle (OP1).
  always_comb begin
    slotErr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slotState_d[i] = slotState_q[i];
      slotCmd_d[i]   = slotCmd_q[i];
      slotOp1_d[i]   = slotOp1_q[i];
      slotOp2_d[i]   = slotOp2_q[i];
      case (slotState_q[i])
        SLOT_EMPTY: begin
          if (reqCmd[i] != '0) begin
            slotCmd_d[i]   = reqCmd[i];
            slotOp1_d[i]   = reqData[i];
            slotState_d[i] = SLOT_OP1;
          end
        end
        SLOT_OP1: begin
          slotOp2_d[i]   = reqData[i];
          slotState_d[i] = SLOT_PENDING;
        end
        SLOT_PENDING: begin
          if (reqCmd[i] != '0) begin
            slotErr = 1'b1;
          end
          if (grantFire && pickIdx == 2'(i)) begin
            slotState_d[i] = SLOT_SERVICE;
          end
        end
        SLOT_SERVICE: begin
          if (reqCmd[i] != '0) begin
            slotErr = 1'b1;
          end
          if (done && grant_q == 2'(i)) begin
            slotState_d[i] = SLOT_EMPTY;
          end
        end
        default: slotState_d[i] = SLOT_EMPTY;
      endcase
    end
  end

  // Response return: a one-cycle registered pulse on the granted port only.
  // Code 3 is never forwarded, so an out-of-range engine code becomes an error.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      resp_d[i]  = 2'b00;
      rdata_d[i] = '0;
      if (respFire && grant_q == 2'(i)) begin
        resp_d[i]  = (eng_resp_in == 2'd1) ? 2'd1 : 2'd2;
        rdata_d[i] = eng_data_in;
      end else if (timeoutFire && grant_q == 2'(i)) begin
        resp_d[i]  = 2'd2;
      end
    end
  end

  assign errProt_d = errProt_q || slotErr ||
                     ((eng_resp_in != 2'b00) && (engState_q != ENG_WAIT_RESP));

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      engState_q <= ENG_IDLE;
      grant_q    <= 2'd0;
      ptr_q      <= 2'd0;
      cnt_q      <= '0;
      errProt_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slotState_q[i] <= SLOT_EMPTY;
        slotCmd_q[i]   <= '0;
        slotOp1_q[i]   <= '0;
        slotOp2_q[i]   <= '0;
        resp_q[i]      <= 2'b00;
        rdata_q[i]     <= '0;
      end
    end else begin
      engState_q <= engState_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      errProt_q  <= errProt_d;
      for (int i = 0; i < 4; i++) begin
        slotState_q[i] <= slotState_d[i];
        slotCmd_q[i]   <= slotCmd_d[i];
        slotOp1_q[i]   <= slotOp1_d[i];
        slotOp2_q[i]   <= slotOp2_d[i];
        resp_q[i]      <= resp_d[i];
        rdata_q[i]     <= rdata_d[i];
      end
    end
  end

  assign out_resp1    = resp_q[0];
  assign out_resp2    = resp_q[1];
  assign out_resp3    = resp_q[2];
  assign out_resp4    = resp_q[3];
  assign out_data1    = rdata_q[0];
  assign out_data2    = rdata_q[1];
  assign out_data3    = rdata_q[2];
  assign out_data4    = rdata_q[3];
  assign busy         = (engState_q != ENG_IDLE);
  assign err_protocol = errProt_q;

endmodule

// File: tb/tb_calc1_port_sched.sv
// tb_calc1_port_sched
//
// Bench for calc1_port_sched. The bench contains an engine model. The model
// compares every command replayed to the engine against an expected-engine
// queue, and then answers with the response stored in that queue entry. A
// response monitor pops an expected-result queue each time a port returns a
// response.
module tb_calc1_port_sched;

  localparam int DATA_W  = 32;
  localparam int CMD_W   = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
  } resExp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          delay;
  } engExp_t;

  logic                   c_clk;
  logic                   reset_n;
  logic [3:0][CMD_W-1:0]  reqCmd;
  logic [3:0][DATA_W-1:0] reqData;
  logic [3:0][1:0]        outResp;
  logic [3:0][DATA_W-1:0] outData;
  logic [CMD_W-1:0]       eng_cmd_out;
  logic [DATA_W-1:0]      eng_data_out;
  logic [1:0]             eng_resp_in;
  logic [DATA_W-1:0]      eng_data_in;
  logic                   busy;
  logic                   err_protocol;

  logic [1:0]             engRespM, engRespT;
  logic [DATA_W-1:0]      engDataM, engDataT;

  resExp_t resQ[$];
  engExp_t engQ[$];

  int checkCount = 0;
  int errorCount = 0;
  int respCount  = 0;
  int cyc        = 0;
  int stimCyc    = 0;
  int lastIssue1Cyc = 0;
  int lastIssue2Cyc = 0;
  int lastRespCyc   = 0;

  assign eng_resp_in = engRespM | engRespT;
  assign eng_data_in = engDataM | engDataT;

  calc1_port_sched #(
    .DATA_W (DATA_W),
    .CMD_W  (CMD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .c_clk       (c_clk),
    .reset_n     (reset_n),
    .req1_cmd_in (reqCmd[0]),
    .req1_data_in(reqData[0]),
    .req2_cmd_in (reqCmd[1]),
    .req2_data_in(reqData[1]),
    .req3_cmd_in (reqCmd[2]),
    .req3_data_in(reqData[2]),
    .req4_cmd_in (reqCmd[3]),
    .req4_data_in(reqData[3]),
    .out_resp1   (outResp[0]),
    .out_data1   (outData[0]),
    .out_resp2   (outResp[1]),
    .out_data2   (outData[1]),
    .out_resp3   (outResp[2]),
    .out_data3   (outData[2]),
    .out_resp4   (outResp[3]),
    .out_data4   (outData[3]),
    .eng_cmd_out (eng_cmd_out),
    .eng_data_out(eng_data_out),
    .eng_resp_in (eng_resp_in),
    .eng_data_in (eng_data_in),
    .busy        (busy),
    .err_protocol(err_protocol)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic expectEng(input logic [3:0] cmd, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [1:0] resp,
                           input logic [31:0] rdata, input int delay);
    engExp_t e;
    e.cmd = cmd; e.op1 = op1; e.op2 = op2;
    e.resp = resp; e.rdata = rdata; e.delay = delay;
    engQ.push_back(e);
  endtask

  task automatic expectRes(input int port, input logic [1:0] resp,
                           input logic [31:0] data);
    resExp_t r;
    r.port = port; r.resp = resp; r.data = data;
    resQ.push_back(r);
  endtask

  // Two-cycle command on every port selected by mask: cmd+op1, then op2.
  task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] cmd,
                               input logic [3:0][31:0] op1v,
                               input logic [3:0][31:0] op2v);
    @(posedge c_clk); #1;
    stimCyc = cyc;
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) begin
        reqCmd[p]  = cmd;
        reqData[p] = op1v[p];
      end
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) begin
        reqCmd[p]  = '0;
        reqData[p] = op2v[p];
      end
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) reqData[p] = '0;
    end
  endtask

  task automatic applyReset();
    @(posedge c_clk); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstErr", err_protocol, 0);
    checkOutput("rstEngCmd", eng_cmd_out, 0);
    checkOutput("rstEngData", eng_data_out, 0);
    checkOutput("rstResp", outResp, 0);
    checkOutput("rstData", |outData, 0);
    repeat (2) @(posedge c_clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic waitResp(input int target, input int budget, input string tag);
    int n = 0;
    while (respCount < target && n < budget) begin
      @(negedge c_clk);
      n++;
    end
    checkOutput(tag, respCount, target);
  endtask

  // Engine model: checks the replayed command against the queue, then
  // answers after the requested delay. A queue entry with resp 0 stays silent.
  initial begin : engineModel
    engExp_t e;
    engRespM = 2'b00;
    engDataM = '0;
    forever begin
      @(negedge c_clk);
      if (eng_cmd_out != '0) begin
        lastIssue1Cyc = cyc;
        if (engQ.size() == 0) begin
          checkOutput("engUnexpected", eng_cmd_out, 0);
        end else begin
          e = engQ.pop_front();
          checkOutput("engCmd", eng_cmd_out, e.cmd);
          checkOutput("engOp1", eng_data_out, e.op1);
          @(negedge c_clk);
          lastIssue2Cyc = cyc;
          checkOutput("engCmd2", eng_cmd_out, 0);
          checkOutput("engOp2", eng_data_out, e.op2);
          if (e.resp != 2'b00) begin
            repeat (e.delay) @(posedge c_clk);
            @(posedge c_clk); #1;
            engRespM = e.resp;
            engDataM = e.rdata;
            @(posedge c_clk); #1;
            engRespM = 2'b00;
            engDataM = '0;
          end
        end
      end
    end
  end

  // Response monitor: every nonzero out_resp must match the queue head.
  initial begin : respMonitor
    resExp_t r;
    forever begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        if (outResp[p] != 2'b00) begin
          if (resQ.size() == 0) begin
            checkOutput($sformatf("unexpResp%0d", p + 1), outResp[p], 0);
          end else begin
            r = resQ.pop_front();
            checkOutput("respPort", p + 1, r.port);
            checkOutput("respCode", outResp[p], r.resp);
            checkOutput("respData", outData[p], r.data);
            lastRespCyc = cyc;
            respCount++;
          end
        end else if (outData[p] != '0) begin
          checkOutput($sformatf("idleData%0d", p + 1), outData[p], 0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    logic [3:0][31:0] op1v;
    logic [3:0][31:0] op2v;
    int n;
    reset_n  = 1'b0;
    reqCmd   = '0;
    reqData  = '0;
    engRespT = 2'b00;
    engDataT = '0;
    applyReset();

    // 1: single request, latency and pass-through
    $display("[TB] test 1: single request");
    expectEng(4'd1, 32'h1, 32'h01FF_FFFF, 2'd1, 32'h0200_0000, 0);
    expectRes(1, 2'd1, 32'h0200_0000);
    op1v = '0; op2v = '0;
    op1v[0] = 32'h1; op2v[0] = 32'h01FF_FFFF;
    applyStimulus(4'b0001, 4'd1, op1v, op2v);
    waitResp(1, 30, "t1Done");
    checkOutput("t1IssueLat", lastIssue1Cyc - stimCyc, 3);
    checkOutput("t1RespLat", lastRespCyc - lastIssue2Cyc, 2);

    // 2: all four ports at once, pointer back at port 1
    $display("[TB] test 2: four simultaneous requests");
    applyReset();
    for (int p = 0; p < 4; p++) begin
      op1v[p] = 32'(p + 1);
      op2v[p] = 32'h10 * 32'(p + 1);
      expectEng(4'd1, op1v[p], op2v[p], 2'd1, 32'h11 * 32'(p + 1), 1);
      expectRes(p + 1, 2'd1, 32'h11 * 32'(p + 1));
    end
    applyStimulus(4'b1111, 4'd1, op1v, op2v);
    waitResp(5, 80, "t2Done");

    // 3: port1 reissues at R+1 while port3 is pending
    $display("[TB] test 3: fairness");
    op1v = '0; op2v = '0;
    op1v[0] = 32'h100; op2v[0] = 32'h23;
    op1v[2] = 32'h300; op2v[2] = 32'h45;
    expectEng(4'd1, 32'h100, 32'h23, 2'd1, 32'h123, 2);
    expectEng(4'd1, 32'h300, 32'h45, 2'd1, 32'h345, 2);
    expectRes(1, 2'd1, 32'h123);
    expectRes(3, 2'd1, 32'h345);
    applyStimulus(4'b0101, 4'd1, op1v, op2v);
    n = 0;
    do begin
      @(negedge c_clk);
      n++;
    end while (eng_resp_in == 2'b00 && n < 40);
    checkOutput("t3EngResp", eng_resp_in, 1);
    expectEng(4'd1, 32'h7, 32'h8, 2'd1, 32'hF, 0);
    expectRes(1, 2'd1, 32'hF);
    op1v = '0; op2v = '0;
    op1v[0] = 32'h7; op2v[0] = 32'h8;
    applyStimulus(4'b0001, 4'd1, op1v, op2v);
    waitResp(8, 80, "t3Done");

    // 4: engine silent on port2, port4 waits behind it
    $display("[TB] test 4: timeout");
    op1v = '0; op2v = '0;
    op1v[1] = 32'hAAAA; op2v[1] = 32'h5555;
    op1v[3] = 32'h1000; op2v[3] = 32'h0234;
    expectEng(4'd1, 32'hAAAA, 32'h5555, 2'd0, 32'h0, 0);
    expectEng(4'd1, 32'h1000, 32'h0234, 2'd1, 32'h1234, 1);
    expectRes(2, 2'd2, 32'h0);
    expectRes(4, 2'd1, 32'h1234);
    applyStimulus(4'b1010, 4'd1, op1v, op2v);
    n = 0;
    do begin
      @(negedge c_clk);
      n++;
    end while (outResp[1] == 2'b00 && n < TIMEOUT + 30);
    checkOutput("t4RespCode", outResp[1], 2);
    checkOutput("t4Latency", cyc - lastIssue2Cyc, TIMEOUT);
    checkOutput("t4Busy", busy, 0);
    waitResp(10, 40, "t4Done");
    checkOutput("t4ErrClean", err_protocol, 0);

    // 5: extra command on port4 while its slot is pending
    $display("[TB] test 5: protocol violation");
    op1v = '0; op2v = '0;
    op1v[0] = 32'h11; op2v[0] = 32'h22;
    op1v[3] = 32'h40; op2v[3] = 32'h2;
    expectEng(4'd1, 32'h11, 32'h22, 2'd1, 32'h33, 6);
    expectEng(4'd1, 32'h40, 32'h2, 2'd2, 32'hDEAD, 0);
    expectRes(1, 2'd1, 32'h33);
    expectRes(4, 2'd2, 32'hDEAD);
    applyStimulus(4'b1001, 4'd1, op1v, op2v);
    @(negedge c_clk);
    checkOutput("t5ErrBefore", err_protocol, 0);
    @(posedge c_clk); #1;
    reqCmd[3]  = 4'd2;
    reqData[3] = 32'h99;
    @(posedge c_clk); #1;
    reqCmd[3]  = '0;
    reqData[3] = '0;
    @(negedge c_clk);
    checkOutput("t5ErrSet", err_protocol, 1);
    waitResp(12, 60, "t5Done");
    repeat (10) @(negedge c_clk);

    // 6: reset during WAIT_RESP, stray late response, fresh request
    $display("[TB] test 6: reset mid-operation");
    expectEng(4'd3, 32'h5, 32'h6, 2'd0, 32'h0, 0);
    op1v = '0; op2v = '0;
    op1v[0] = 32'h5; op2v[0] = 32'h6;
    applyStimulus(4'b0001, 4'd3, op1v, op2v);
    repeat (4) @(negedge c_clk);
    checkOutput("t6BusyWait", busy, 1);
    applyReset();
    @(posedge c_clk); #1;
    engRespT = 2'd1;
    engDataT = 32'h55;
    @(posedge c_clk); #1;
    engRespT = 2'b00;
    engDataT = '0;
    @(negedge c_clk);
    checkOutput("t6ErrStray", err_protocol, 1);
    expectEng(4'd1, 32'h10, 32'h20, 2'd1, 32'h30, 2);
    expectRes(3, 2'd1, 32'h30);
    op1v = '0; op2v = '0;
    op1v[2] = 32'h10; op2v[2] = 32'h20;
    applyStimulus(4'b0100, 4'd1, op1v, op2v);
    waitResp(13, 40, "t6Done");
    repeat (5) @(negedge c_clk);

    checkOutput("resQEmpty", resQ.size(), 0);
    checkOutput("engQEmpty", engQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/calc1_port_sched.md
Name: calc1_port_sched

Overview:
- Shares one single-port calc1 engine among four requesters.
- Buffers each requester's two-cycle command (cmd+operand1, then operand2).
- Picks pending requests round-robin and replays each to the engine with the same two-cycle protocol.
- Routes the engine response back to the originating port. Sits between the four request ports and the engine, with a response timeout guard.

Parameters:
- DATA_W, 32, operand/result width.
- CMD_W, 4, command width.
- TIMEOUT, 64, max cycles in WAIT_RESP before a synthetic error response (must be >= 2).

Ports:
- c_clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqN_cmd_in (N=1..4)  in  CMD_W  requester command, 0 = no request.
- reqN_data_in (N=1..4)  in  DATA_W  operand1 in the cmd cycle, operand2 in the next cycle.
- out_respN (N=1..4)  out  2  0 none, 1 success, 2 error (engine error or timeout), 3 never driven.
- out_dataN (N=1..4)  out  DATA_W  result, valid only while out_respN != 0, else 0.
- eng_cmd_out  out  CMD_W  command to engine.
- eng_data_out  out  DATA_W  operand to engine.
- eng_resp_in  in  2  engine response, nonzero for one cycle.
- eng_data_in  in  DATA_W  engine result.
- busy  out  1  FSM not in IDLE.
- err_protocol  out  1  sticky violation flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; all slots EMPTY; FSM IDLE; round-robin pointer = port 1; timeout counter 0.
  - Reset mid-operation abandons any in-flight request; no response is ever returned for it.
  - The engine must be reset together with this block.
- Per-port slot FSM: EMPTY -> OP1 -> PENDING -> (granted) -> EMPTY on return.
  - EMPTY, reqN_cmd_in != 0: latch cmd and data as op1; go to OP1.
  - OP1: latch reqN_data_in as op2 unconditionally; go to PENDING. reqN_cmd_in is ignored in this cycle.
  - reqN_cmd_in != 0 while the slot is PENDING or in service: request dropped, err_protocol set.
- Engine FSM: IDLE -> ISSUE1 -> ISSUE2 -> WAIT_RESP -> IDLE.
  - IDLE: if any slot is PENDING, grant the first PENDING port at or after the pointer (wrap 4 -> 1). Pointer <- granted+1 (wraps). Go to ISSUE1.
  - ISSUE1: eng_cmd_out = latched cmd, eng_data_out = op1.
  - ISSUE2: eng_cmd_out = 0, eng_data_out = op2; counter cleared.
  - WAIT_RESP: eng_cmd_out = 0, eng_data_out = 0; counter increments each cycle.
  - eng_cmd_out and eng_data_out are 0 in IDLE.
- Response return:
  - eng_resp_in != 0 sampled in WAIT_RESP at cycle R: in cycle R+1, out_respG = eng_resp_in and out_dataG = eng_data_in for exactly one cycle.
  - Granted slot -> EMPTY and FSM -> IDLE at the same edge. A new cmd on that port is accepted from cycle R+1.
  - The FSM may grant again in cycle R+1, giving back-to-back service.
- Timeout: counter reaches TIMEOUT with no response -> out_respG = 2, out_dataG = 0 for one cycle; slot freed; IDLE.
- Response arriving in the same cycle the counter hits TIMEOUT: the real response wins.
- eng_resp_in != 0 outside WAIT_RESP: ignored, err_protocol set.
- Latency: op2 at cycle T -> engine sees cmd/op1 at T+2, op2 at T+3 (when idle).
- Data is passed through unmodified; no arithmetic in this block.
- Simultaneous capture on several ports is always allowed; arbitration affects only the order of service.
- Ungranted out_resp* stay 0.

Test Plan:
1. Single request, engine model: port1 cmd 1, op1 0x1, op2 0x1FF_FFFF at cycles 0/1 -> engine sees cmd 1/0x1 at cycle 3 and 0/0x1FF_FFFF at cycle 4. Engine answers resp 1, data 0x200_0000 -> out_resp1 = 1, out_data1 = 0x200_0000 for one cycle; ports 2-4 stay 0.
2. Four ports issue cmd 1 in the same cycle (op1 = N, op2 = 0x10*N), pointer at 1 -> engine served 1,2,3,4; each port gets its own result (0x11*N); pointer ends at 1.
3. Fairness: port1 reissues at R+1 while port3 is PENDING -> port3 granted before port1.
4. Engine silent -> exactly TIMEOUT cycles after ISSUE2, out_resp2 = 2 and out_data2 = 0; busy drops next cycle; next pending request proceeds.
5. Port4 drives cmd 2 while its slot is PENDING -> err_protocol = 1, original request completes normally, extra request never reaches the engine.
6. Drop reset_n low during WAIT_RESP -> all outputs 0 immediately; late eng_resp_in after release is ignored and sets err_protocol; a fresh request completes correctly.
